// File: rtl/inst_mem_arbiter.sv
// ============================================================================
// Module      : inst_mem_arbiter
// Description : Owns the instruction-memory port. Packs loaded 32-bit
//               instructions into 64-bit words, then serves fetch and debug
//               reads. Optional debug port enabled by INST_ARB_DEBUG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_arbiter #(
    parameter int          ADDR_W   = 15,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_valid_i,
    input  logic [31:0]       ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    input  logic [31:0]       fetch_addr_i,
    input  logic              fetch_hold_i,
    output logic              fetch_stall_o,
    output logic [63:0]       fetch_data_o,
    output logic              cpu_start_o,
    output logic [ADDR_W:0]   words_loaded_o,
    output logic              load_ovf_o,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [63:0]       dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    input  logic [63:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] C_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [31:0]       hi_q;
    logic              odd_q;
    logic [ADDR_W:0]   wr_ptr_q;
    logic              ovf_q;
    logic              replay_q;
    logic              dbg_rvalid_q;

    logic              w_accept;
    logic              w_wr_req;
    logic              w_full;
    logic              w_do_wr;
    logic              w_dbg_gnt;
    logic              w_unused;

    assign w_accept = rstn && (state_q == ST_LOAD) && ld_valid_i;
    assign w_wr_req = w_accept && (odd_q || ld_last_i);
    // wr_ptr saturates at 2^ADDR_W, so its top bit marks a full memory
    assign w_full   = wr_ptr_q[ADDR_W];
    assign w_do_wr  = w_wr_req && !w_full;

`ifdef INST_ARB_DEBUG_EN
    assign w_dbg_gnt    = rstn && dbg_req_i &&
                          (((state_q == ST_LOAD) && !w_do_wr) ||
                           ((state_q == ST_RUN) && fetch_hold_i && !replay_q));
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign dbg_rdata_o  = mem_rdata_i;
    assign w_unused     = ^{fetch_addr_i[31:ADDR_W]};
`else
    assign w_dbg_gnt    = 1'b0;
    assign dbg_rvalid_o = 1'b0;
    assign dbg_rdata_o  = 64'd0;
    assign w_unused     = ^{fetch_addr_i[31:ADDR_W], dbg_req_i, dbg_rvalid_q};
`endif

    assign dbg_gnt_o      = w_dbg_gnt;
    assign fetch_data_o   = mem_rdata_i;
    assign words_loaded_o = wr_ptr_q;
    assign load_ovf_o     = ovf_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ld_ready_o    = 1'b0;
        fetch_stall_o = 1'b1;
        cpu_start_o   = 1'b0;
        mem_en_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = fetch_addr_i[ADDR_W-1:0];
        mem_wdata_o   = odd_q ? {hi_q, ld_data_i} : {ld_data_i, NOP_INST};
        if (rstn) begin
            case (state_q)
                ST_LOAD: begin
                    ld_ready_o = 1'b1;
                    if (w_do_wr) begin
                        mem_en_o   = 1'b1;
                        mem_we_o   = 1'b1;
                        mem_addr_o = wr_ptr_q[ADDR_W-1:0];
                    end else if (w_dbg_gnt) begin
                        mem_en_o   = 1'b1;
                        mem_addr_o = dbg_addr_i;
                    end
                    if (w_accept && ld_last_i) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    cpu_start_o = 1'b1;
                    mem_en_o    = 1'b1;
                    state_d     = ST_RUN;
                end
                ST_RUN: begin
                    mem_en_o = 1'b1;
                    // replay cycle lets fetch re-read its held address
                    fetch_stall_o = w_dbg_gnt || replay_q;
                    if (w_dbg_gnt) begin
                        mem_addr_o = dbg_addr_i;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hi_q         <= 32'd0;
            odd_q        <= 1'b0;
            wr_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            replay_q     <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            if (w_accept) begin
                if (odd_q || ld_last_i) begin
                    odd_q <= 1'b0;
                end else begin
                    hi_q  <= ld_data_i;
                    odd_q <= 1'b1;
                end
            end
            if (w_do_wr) begin
                wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
            end
            if (w_wr_req && w_full) begin
                ovf_q <= 1'b1;
            end
            replay_q     <= w_dbg_gnt && (state_q == ST_RUN);
            dbg_rvalid_q <= w_dbg_gnt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_arbiter.sv
// ============================================================================
// Module      : tb_inst_mem_arbiter
// Description : Directed bench for inst_mem_arbiter with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_mem_arbiter;

    localparam int          ADDR_W   = 2;
    localparam logic [31:0] NOP_INST = 32'hFC00_0000;
`ifdef INST_ARB_DEBUG_EN
    localparam logic        DBG = 1'b1;
`else
    localparam logic        DBG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [31:0]       fetch_addr;
    logic              fetch_hold;
    logic              fetch_stall;
    logic [63:0]       fetch_data;
    logic              cpu_start;
    logic [ADDR_W:0]   words_loaded;
    logic              load_ovf;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [63:0]       dbg_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    logic [63:0]       mem [0:(1<<ADDR_W)-1];
    int                wr_cnt = 0;
    int                n_chk  = 0;
    int                n_err  = 0;
    int                wr_base;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    inst_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .NOP_INST (NOP_INST)
    ) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .ld_valid_i     (ld_valid),
        .ld_data_i      (ld_data),
        .ld_last_i      (ld_last),
        .ld_ready_o     (ld_ready),
        .fetch_addr_i   (fetch_addr),
        .fetch_hold_i   (fetch_hold),
        .fetch_stall_o  (fetch_stall),
        .fetch_data_o   (fetch_data),
        .cpu_start_o    (cpu_start),
        .words_loaded_o (words_loaded),
        .load_ovf_o     (load_ovf),
        .dbg_req_i      (dbg_req),
        .dbg_addr_i     (dbg_addr),
        .dbg_gnt_o      (dbg_gnt),
        .dbg_rvalid_o   (dbg_rvalid),
        .dbg_rdata_o    (dbg_rdata),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 3 later.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] d, input logic last, input logic exp_we);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        #3;
        chk("ld_we", {63'd0, mem_we}, {63'd0, exp_we});
        next();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = 32'd0;
        ld_last    = 1'b0;
        fetch_addr = 32'd0;
        fetch_hold = 1'b0;
        dbg_req    = 1'b0;
        dbg_addr   = '0;
        next();
        next();
        #3;
        chk("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
        chk("rst_stall", {63'd0, fetch_stall}, 64'd1);
        chk("rst_start", {63'd0, cpu_start}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_words", {61'd0, words_loaded}, 64'd0);
        chk("rst_ovf", {63'd0, load_ovf}, 64'd0);
        chk("rst_gnt", {63'd0, dbg_gnt}, 64'd0);
        chk("rst_rvalid", {63'd0, dbg_rvalid}, 64'd0);
        next();
        rstn = 1'b1;
        #3;
        chk("ld_ready_after_rst", {63'd0, ld_ready}, 64'd1);
        next();

        // Four instructions pack into two words
        load(32'h11, 1'b0, 1'b0);
        load(32'h22, 1'b0, 1'b1);
        load(32'h33, 1'b0, 1'b0);
        load(32'h44, 1'b1, 1'b1);
        #3;
        chk("t1_start", {63'd0, cpu_start}, 64'd1);
        chk("t1_ld_ready", {63'd0, ld_ready}, 64'd0);
        chk("t1_stall_start", {63'd0, fetch_stall}, 64'd1);
        chk("t1_start_en", {63'd0, mem_en}, 64'd1);
        chk("t1_words", {61'd0, words_loaded}, 64'd2);
        chk("t1_word0", mem[0], 64'h0000_0011_0000_0022);
        chk("t1_word1", mem[1], 64'h0000_0033_0000_0044);
        next();
        #3;
        chk("t1_run_start", {63'd0, cpu_start}, 64'd0);
        chk("t1_run_stall", {63'd0, fetch_stall}, 64'd0);
        chk("t1_fetch_data0", fetch_data, 64'h0000_0011_0000_0022);
        next();

        // Upper fetch address bits are ignored
        fetch_addr = 32'hFFFF_FFF5;
        #3;
        chk("wrap_addr", {62'd0, mem_addr}, 64'd1);
        chk("run_we", {63'd0, mem_we}, 64'd0);
        next();
        #3;
        chk("fetch_data1", fetch_data, 64'h0000_0033_0000_0044);
        next();

        // Debug request without interlock is never granted
        dbg_req    = 1'b1;
        dbg_addr   = 2'd1;
        fetch_hold = 1'b0;
        fetch_addr = 32'd6;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("nohold_gnt", {63'd0, dbg_gnt}, 64'd0);
            chk("nohold_addr", {62'd0, mem_addr}, 64'd2);
            next();
        end

        fetch_hold = 1'b1;
        fetch_addr = 32'd0;
        #3;
        chk("dbg_gnt", {63'd0, dbg_gnt}, {63'd0, DBG});
        chk("dbg_addr_mux", {62'd0, mem_addr}, {62'd0, DBG, 1'b0} >> 1 | {63'd0, DBG});
        chk("dbg_stall", {63'd0, fetch_stall}, {63'd0, DBG});
        next();
        #3;
        chk("replay_gnt", {63'd0, dbg_gnt}, 64'd0);
        chk("replay_stall", {63'd0, fetch_stall}, {63'd0, DBG});
        chk("dbg_rvalid", {63'd0, dbg_rvalid}, {63'd0, DBG});
        chk("dbg_rdata", dbg_rdata, DBG ? 64'h0000_0033_0000_0044 : 64'd0);
        chk("replay_addr", {62'd0, mem_addr}, 64'd0);
        next();
        #3;
        chk("regrant", {63'd0, dbg_gnt}, {63'd0, DBG});
        dbg_req = 1'b0;
        next();
        fetch_hold = 1'b0;

        // Reset in the middle of a load discards the partial word
        rstn = 1'b0;
        next();
        rstn = 1'b1;
        next();
        load(32'hAA, 1'b0, 1'b0);
        rstn = 1'b0;
        next();
        #3;
        chk("midrst_words", {61'd0, words_loaded}, 64'd0);
        chk("midrst_start", {63'd0, cpu_start}, 64'd0);
        next();
        rstn = 1'b1;
        next();

        // Gapped three-instruction load, debug colliding with a write
        wr_base = wr_cnt;
        load(32'h55, 1'b0, 1'b0);
        #3;
        chk("gap_en", {63'd0, mem_en}, 64'd0);
        next();
        ld_valid = 1'b1;
        ld_data  = 32'h66;
        dbg_req  = 1'b1;
        dbg_addr = 2'd3;
        #3;
        chk("coll_we", {63'd0, mem_we}, 64'd1);
        chk("coll_gnt", {63'd0, dbg_gnt}, 64'd0);
        next();
        ld_valid = 1'b0;
        #3;
        chk("gap_we", {63'd0, mem_we}, 64'd0);
        chk("load_dbg_gnt", {63'd0, dbg_gnt}, {63'd0, DBG});
        next();
        dbg_req = 1'b0;
        #3;
        chk("load_dbg_rvalid", {63'd0, dbg_rvalid}, {63'd0, DBG});
        next();
        load(32'h77, 1'b1, 1'b1);
        #3;
        chk("t2_start", {63'd0, cpu_start}, 64'd1);
        chk("t2_words", {61'd0, words_loaded}, 64'd2);
        chk("t2_word0", mem[0], 64'h0000_0055_0000_0066);
        chk("t2_word1", mem[1], 64'h0000_0077_FC00_0000);
        chk("t2_wr_cnt", 64'(wr_cnt - wr_base), 64'd2);
        next();

        // Overflow: ten instructions into a four-word memory
        rstn = 1'b0;
        next();
        rstn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            load(32'(i), (i == 10), ((i % 2) == 0) && (i != 10));
        end
        #3;
        chk("ovf_start", {63'd0, cpu_start}, 64'd1);
        chk("ovf_words", {61'd0, words_loaded}, 64'd4);
        chk("ovf_flag", {63'd0, load_ovf}, 64'd1);
        chk("ovf_word0", mem[0], 64'h0000_0001_0000_0002);
        chk("ovf_word3", mem[3], 64'h0000_0007_0000_0008);
        next();
        #3;
        chk("ovf_sticky", {63'd0, load_ovf}, 64'd1);
        next();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_mem_arbiter.md
# inst_mem_arbiter

Owns the single port of the 64-bit instruction memory and shares it among three requesters: the boot program loader (writes), the fetch stage (reads) and an optional debug reader. After reset it runs a load phase that packs 32-bit instructions into 64-bit memory words. It then releases the core with a start pulse and gives fetch the port every cycle, except for debug reads that are slotted into fetch interlock cycles. It sits between the top level, the loader, fetch and the instruction memory macro.

## Interface
- ADDR_W, 15: memory word-address width; depth = 2^ADDR_W 64-bit words
- NOP_INST, 32'h0000_0000: pad instruction for an odd final load word
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- ld_valid  in  1  loader instruction valid
- ld_data  in  32  loader instruction
- ld_last  in  1  marks final instruction; qualified by ld_valid
- ld_ready  out  1  loader handshake ready
- fetch_addr  in  32  fetch word address (64-bit word index)
- fetch_hold  in  1  fetch pipeline currently interlocked
- fetch_stall  out  1  OR'd into fetch interlock by top
- fetch_data  out  64  = mem_rdata
- cpu_start  out  1  one-cycle pulse on entering RUN
- words_loaded  out  ADDR_W+1  64-bit words written
- load_ovf  out  1  sticky: load exceeded depth
- dbg_req  in  1  debug read request
- dbg_addr  in  ADDR_W  debug word address
- dbg_gnt  out  1  debug request granted this cycle
- dbg_rvalid  out  1  dbg_rdata valid
- dbg_rdata  out  64  = mem_rdata
- mem_en, mem_we  out  1 each  memory port controls (combinational)
- mem_addr  out  ADDR_W  memory address (combinational)
- mem_wdata  out  64  memory write data (combinational)
- mem_rdata  in  64  memory read data, 1-cycle synchronous latency

## Operation
- States: LOAD, START, RUN. Reset → LOAD. RUN exits only on reset.
- LOAD:
  - ld_ready=1 and fetch_stall=1.
  - Handshake: an instruction is accepted when ld_valid & ld_ready.
  - Even-position instruction: latched into hi_reg and becomes bits [63:32]; no write.
  - Odd-position instruction: write {hi_reg, ld_data} to wr_ptr in the same cycle (mem_en=mem_we=1); wr_ptr and words_loaded increment.
  - ld_last on an even-position instruction: write {ld_data, NOP_INST} in the same cycle.
  - Accepting ld_last moves the state to START.
  - A write at wr_ptr == 2^ADDR_W is suppressed, sets load_ovf, and does not increment words_loaded. Acceptance continues.
- START, one cycle:
  - cpu_start=1, fetch_stall=1, ld_ready=0.
  - mem_addr=fetch_addr with mem_en=1, which primes the read; next state is RUN.
- RUN:
  - ld_ready=0; ld_valid is ignored.
  - Default: mem_en=1, mem_we=0, mem_addr=fetch_addr[ADDR_W-1:0].
  - Debug grant: when dbg_req & fetch_hold, set dbg_gnt=1 and mem_addr=dbg_addr.
  - fetch_stall=1 in the grant cycle and the following cycle (replay), so fetch re-reads its held address before the interlock can release.
  - No back-to-back debug grants: a grant is blocked in the replay cycle.
- Debug in LOAD: granted only in cycles without a loader write.
- dbg_rvalid=1 exactly one cycle after dbg_gnt.
- Fetch address bits above ADDR_W-1 are ignored (address wraps).

## Timing
- Reset values: state LOAD, ld_ready=0 during reset (1 in the first cycle after), fetch_stall=1, cpu_start=0, words_loaded=0, load_ovf=0, dbg_gnt=0, dbg_rvalid=0, mem_en=0, mem_we=0, hi_reg=0.
- Load write occurs in the acceptance cycle (0 latency).
- cpu_start rises one cycle after ld_last is accepted.
- fetch_stall falls one cycle after cpu_start.
- Debug read latency is 1 cycle. A debug request in RUN waits until fetch_hold=1 and no replay cycle is active.
- A dbg_req that coincides with a loader write waits one cycle.
- Reset mid-load discards the partial hi_reg and all counters; the loader must restart from instruction 0.

## Configuration
- INST_ARB_DEBUG_EN defined: the debug port behaves as described above.
- INST_ARB_DEBUG_EN undefined:
  - dbg_req and dbg_addr are ignored.
  - dbg_gnt, dbg_rvalid and dbg_rdata are tied to 0.
  - fetch_stall in RUN is constant 0.

## Test plan
- Load 4 instructions 0x11,0x22,0x33,0x44 (last on 0x44) → writes word0={0x11,0x22}, word1={0x33,0x44}; words_loaded=2; cpu_start pulses 1 cycle later.
- Load 3 instructions with NOP_INST=0xFC000000 → word1={0x33,0xFC000000}; words_loaded=2.
- ld_valid gapped every other cycle → same memory image; no write without a handshake.
- ADDR_W=2, load 10 instructions → words 0..3 written; load_ovf=1; words_loaded=4; START still reached.
- RUN with fetch_hold=1 and dbg_req at addr 1 → dbg_gnt 1 cycle; dbg_rvalid next cycle with word1; fetch_stall high both cycles.
- dbg_req with fetch_hold=0 for 5 cycles → no grant; mem_addr tracks fetch_addr. Reset asserted mid-load → state LOAD, counters 0.
